// File: rtl/uart_rx_word_packer.sv
// Packs UART receive bytes into little-endian 32-bit words and queues them in a
// first-word-fall-through FIFO; a partial word is flushed after an idle timeout.
module uart_rx_word_packer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_CLKS = 1000
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_n,
    input  logic                        i_Rx_DV,
    input  logic [7:0]                  i_Rx_Byte,
    output logic                        o_Word_Valid,
    output logic [31:0]                 o_Word,
    output logic [2:0]                  o_Word_Bytes,
    input  logic                        i_Word_Ready,
    output logic                        o_Overrun,
    input  logic                        i_Clear_Overrun,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
        $error("TIMEOUT_CLKS must be at least 2");
    end

    typedef enum logic {
        S_IDLE,
        S_COLLECT
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_count, w_count_nxt;
    logic [31:0]   r_staging, w_staging_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;

    logic          w_push;
    logic [31:0]   w_push_word;
    logic [2:0]    w_push_bytes;
    logic [31:0]   w_lane_byte;

    logic [31:0]   r_mem_word  [FIFO_DEPTH];
    logic [2:0]    r_mem_bytes [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_overrun;

    logic          w_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_accept;
    logic          w_drop;

    // Incoming byte positioned in the lane selected by the current byte count.
    assign w_lane_byte = {24'd0, i_Rx_Byte} << {r_count, 3'b000};

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_staging_nxt = r_staging;
        w_timer_nxt   = r_timer;
        w_push        = 1'b0;
        w_push_word   = r_staging;
        w_push_bytes  = {1'b0, r_count};

        case (r_state)
            S_IDLE: begin
                if (i_Rx_DV) begin
                    w_state_nxt   = S_COLLECT;
                    w_count_nxt   = 2'd1;
                    w_staging_nxt = {24'd0, i_Rx_Byte};
                    w_timer_nxt   = '0;
                end
            end
            S_COLLECT: begin
                if (i_Rx_DV) begin
                    w_timer_nxt = '0;
                    if (r_count == 2'd3) begin
                        w_push        = 1'b1;
                        w_push_word   = r_staging | w_lane_byte;
                        w_push_bytes  = 3'd4;
                        w_state_nxt   = S_IDLE;
                        w_count_nxt   = 2'd0;
                        w_staging_nxt = '0;
                    end else begin
                        w_count_nxt   = r_count + 2'd1;
                        w_staging_nxt = r_staging | w_lane_byte;
                    end
                end else if (r_timer == TIMER_LAST) begin
                    // Idle timeout: flush the partial word; unused lanes are already zero.
                    w_push        = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = 2'd0;
                    w_staging_nxt = '0;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_staging <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_staging <= w_staging_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid & i_Word_Ready;
    assign w_full   = (r_level == LEVEL_FULL);
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;

    always_ff @(posedge i_Clock) begin
        if (w_accept) begin
            r_mem_word[r_wr_ptr]  <= w_push_word;
            r_mem_bytes[r_wr_ptr] <= w_push_bytes;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_Clear_Overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Head outputs are gated to zero when empty so reset forces them low at once.
    assign o_Word_Valid = w_valid;
    assign o_Word       = w_valid ? r_mem_word[r_rd_ptr]  : '0;
    assign o_Word_Bytes = w_valid ? r_mem_bytes[r_rd_ptr] : '0;
    assign o_Overrun    = r_overrun;
    assign o_Fifo_Level = r_level;

endmodule
